apb_master: RTL and testbench

//  APB requester driving the psel/pen/paddr/pwdata/pwrite bus of the apb_slave stage

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_cmd_fifo.sv | 47 ++++
 rtl/apb_master.sv | 137 +++++++++++++
 tb/tb_apb_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state and command types for the APB requester
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - synchronous command FIFO with same-cycle push/pop
// Pointers carry one extra MSB so full and empty are distinguishable.
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = apb_cmd_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester: command FIFO feeding a SETUP/ACCESS FSM
// Optional ACCESS wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              pen,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  apb_state_e state;
  cmd_t       in_cmd;
  cmd_t       head;
  logic       full;
  logic       empty;
  logic       pop;
  logic       abort;
  logic       done;

  assign in_cmd    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !full;

  apb_cmd_fifo #(
    .DEPTH   (CMD_DEPTH),
    .entry_t (cmd_t)
  ) u_fifo (
    .clk       (pclk),
    .rst_n     (prst_n),
    .push      (cmd_valid),
    .push_data (in_cmd),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;

  // The abort cycle is itself the TIMEOUT_CYCLES-th ACCESS cycle; pready there is ignored.
  assign abort = (state == ACCESS) && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!pready && !abort) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign abort = (TIMEOUT_CYCLES < 0);
`endif

  assign done = (state == ACCESS) && (pready || abort);
  assign pop  = !empty && ((state == IDLE) || done);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state     <= IDLE;
      psel      <= 1'b0;
      pen       <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            pwrite <= head.write;
            paddr  <= head.addr;
            pwdata <= head.wdata;
            psel   <= 1'b1;
            pen    <= 1'b0;
            state  <= SETUP;
          end
        end
        SETUP: begin
          pen   <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= abort;
            rsp_rdata <= (pwrite || abort) ? '0 : prdata;
            pen       <= 1'b0;
            if (!empty) begin
              // Chain straight into the next SETUP without dropping psel.
              pwrite <= head.write;
              paddr  <= head.addr;
              pwdata <= head.wdata;
              psel   <= 1'b1;
              state  <= SETUP;
            end else begin
              psel  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        prst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        psel, pen, pwrite;
  logic [31:0] paddr, pwdata, prdata, rsp_rdata;
  logic        pready = 1'b1;
  logic        rsp_valid, rsp_err;

  int n_checks = 0;
  int n_pass = 0;
  logic [32:0] rsp_q[$];
  logic        rec = 1'b0;
  logic        psel_q[$];
  logic        pen_q[$];

  apb_master #(
    .ADDR_W(32), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk(pclk), .prst_n(prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 pclk = ~pclk;

  // Slave read data model: fixed word at 0x20, else {addr[15:0], ~addr[15:0]}.
  always_comb prdata = (paddr == 32'h20) ? 32'hCAFEF00D : {paddr[15:0], ~paddr[15:0]};

  always @(negedge pclk) begin
    if (rsp_valid) rsp_q.push_back({rsp_err, rsp_rdata});
    if (rec) begin
      psel_q.push_back(psel);
      pen_q.push_back(pen);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic sync();
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pen_cnt, waits, first, run, ones, bad, nrsp;
    logic got, addr_bad;
    logic [32:0] exp_q[$];

    #12;
    check("rst_psel", psel, 0);
    check("rst_pen", pen, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_paddr", paddr, 0);
    prst_n = 1'b1;

    // 1: single write, zero wait states
    sync();
    send(1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge pclk); check("t1_idle_psel", psel, 0);
    @(negedge pclk);
    check("t1_setup_psel", psel, 1);
    check("t1_setup_pen", pen, 0);
    check("t1_setup_paddr", paddr, 32'h10);
    check("t1_setup_pwdata", pwdata, 32'hDEADBEEF);
    check("t1_setup_pwrite", pwrite, 1);
    @(negedge pclk);
    check("t1_access_psel", psel, 1);
    check("t1_access_pen", pen, 1);
    @(negedge pclk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    check("t1_done_psel", psel, 0);
    check("t1_done_pen", pen, 0);
    @(negedge pclk); check("t1_rsp_pulse", rsp_valid, 0);

    // 2: read with 3 wait states
    pready = 1'b0;
    sync();
    send(1'b0, 32'h20, 32'h0);
    pen_cnt = 0; waits = 0; got = 1'b0; addr_bad = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge pclk);
      if (rsp_valid) got = 1'b1;
      else if (pen) begin
        pen_cnt++;
        if (paddr !== 32'h20) addr_bad = 1'b1;
        if (waits < 3) waits++;
        else pready = 1'b1;
      end
    end
    check("t2_rsp_seen", got, 1);
    check("t2_pen_cycles", pen_cnt, 4);
    check("t2_paddr_stable", addr_bad, 0);
    check("t2_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    check("t2_rsp_err", rsp_err, 0);
    pready = 1'b1;
    idle(2);

    // 3: four back-to-back commands
    rsp_q.delete(); psel_q.delete(); pen_q.delete();
    sync();
    rec = 1'b1;
    send(1'b0, 32'h100, 32'h0);
    send(1'b1, 32'h104, 32'h11111111);
    send(1'b0, 32'h108, 32'h0);
    send(1'b0, 32'h10C, 32'h0);
    idle(8);
    rec = 1'b0;
    first = -1; run = 0; ones = 0; bad = 0;
    foreach (psel_q[k]) if (psel_q[k]) begin
      ones++;
      if (first < 0) first = k;
    end
    if (first >= 0) begin
      for (int k = first; k < psel_q.size() && psel_q[k]; k++) begin
        if (pen_q[k] !== 1'((k - first) % 2)) bad++;
        run++;
      end
    end
    check("t3_psel_run", run, 8);
    check("t3_psel_total", ones, 8);
    check("t3_pen_alternate", bad, 0);
    exp_q = '{{1'b0, 32'h0100FEFF}, {1'b0, 32'h0}, {1'b0, 32'h0108FEF7}, {1'b0, 32'h010CFEF3}};
    check("t3_rsp_count", rsp_q.size(), 4);
    for (int k = 0; k < 4 && k < rsp_q.size(); k++) check($sformatf("t3_rsp%0d", k), rsp_q[k], exp_q[k]);

    // 6: push while popping at 3/4, then fill and refuse
    rsp_q.delete();
    pready = 1'b0;
    sync();
    for (int k = 0; k < 4; k++) send(1'b0, 32'h300 + 32'(4 * k), 32'h0);
    check("t6_ready_at_3", cmd_ready, 1);
    pready = 1'b1;
    send(1'b0, 32'h310, 32'h0);
    pready = 1'b0;
    check("t6_ready_after_pushpop", cmd_ready, 1);
    send(1'b0, 32'h314, 32'h0);
    check("t6_ready_full", cmd_ready, 0);
    send(1'b1, 32'h318, 32'h77777777);
    check("t6_ready_still_full", cmd_ready, 0);
    check("t6_rsp_so_far", rsp_q.size(), 1);
    pready = 1'b1;
    for (int i = 0; i < 40 && rsp_q.size() < 6; i++) @(negedge pclk);
    idle(6);
    exp_q = '{{1'b0, 32'h0300FCFF}, {1'b0, 32'h0304FCFB}, {1'b0, 32'h0308FCF7},
              {1'b0, 32'h030CFCF3}, {1'b0, 32'h0310FCEF}, {1'b0, 32'h0314FCEB}};
    check("t6_rsp_count", rsp_q.size(), 6);
    for (int k = 0; k < 6 && k < rsp_q.size(); k++) check($sformatf("t6_rsp%0d", k), rsp_q[k], exp_q[k]);

    // 4: reset mid-ACCESS
    rsp_q.delete();
    pready = 1'b0;
    sync();
    send(1'b0, 32'h40, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge pclk);
      if (pen) got = 1'b1;
    end
    check("t4_reached_access", got, 1);
    prst_n = 1'b0;
    #1;
    check("t4_rst_psel", psel, 0);
    check("t4_rst_pen", pen, 0);
    check("t4_rst_cmd_ready", cmd_ready, 1);
    check("t4_rst_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    prst_n = 1'b1;
    pready = 1'b1;
    idle(6);
    check("t4_no_rsp", rsp_q.size(), 0);
    check("t4_idle_psel", psel, 0);
    send(1'b1, 32'h44, 32'h12345678);
    idle(6);
    check("t4_post_rsp_count", rsp_q.size(), 1);
    if (rsp_q.size() > 0) check("t4_post_rsp", rsp_q[0], {1'b0, 32'h0});

`ifdef APB_MASTER_TIMEOUT_EN
    // 5: timeout abort, then a normal transfer
    pready = 1'b0;
    sync();
    send(1'b0, 32'h200, 32'h0);
    send(1'b0, 32'h104, 32'h0);
    pen_cnt = 0; nrsp = 0;
    for (int i = 0; i < 80 && nrsp < 2; i++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 1) begin
          check("t5_abort_err", rsp_err, 1);
          check("t5_abort_rdata", rsp_rdata, 0);
          pready = 1'b1;
        end else begin
          check("t5_next_err", rsp_err, 0);
          check("t5_next_rdata", rsp_rdata, 32'h0104FEFB);
        end
      end else if (pen && nrsp == 0) pen_cnt++;
    end
    check("t5_rsp_count", nrsp, 2);
    check("t5_access_cycles", pen_cnt, 16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
